// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives a synchronous word-addressed ROM, pairs each
// returned word with its address and queues {pc, instr} in a small FIFO toward
// decode. Issue is credit-limited so a returning word always has a free slot.
// Execute can redirect fetch at any time. Fetch stops on the halt word.
module instr_fetch #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [31:0]       HALT_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic              halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e              state_q;
    logic                halted_q;
    logic [ADDR_W-1:0]   pc_q,       pc_d;
    logic [ADDR_W-1:0]   req_pc_q,   req_pc_d;
    logic                inflight_q, inflight_d;
    logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic [ADDR_W-1:0]   pc_mem_q    [DEPTH];
    logic [31:0]         instr_mem_q [DEPTH];

    logic                deq_s;
    logic                enq_s;
    logic                halt_cap_s;
    logic                issue_s;
    logic [CNT_W:0]      occupancy_s;

    // ROM address is the live pc; the registered FIFO head feeds decode.
    assign imem_addr = pc_q;
    assign out_valid = (count_q != {CNT_W{1'b0}});
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign halted    = halted_q;

    // Handshake, capture classification and credit-based issue decision.
    always_comb begin
        deq_s       = out_valid & out_ready;
        // A capture in the redirect cycle is squashed: neither enqueued nor halting.
        halt_cap_s  = inflight_q & ~redirect_valid & (imem_instr == HALT_WORD);
        enq_s       = inflight_q & ~redirect_valid & (imem_instr != HALT_WORD);
        // Slots already committed (stored + returning) minus the one leaving now.
        occupancy_s = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(deq_s);
        // The halt word blocks issue in its capture cycle so pc stays just past it.
        issue_s     = (state_q == ST_RUN) & ~redirect_valid & ~halt_cap_s
                      & (occupancy_s < (CNT_W + 1)'(DEPTH));
    end

    // Next-state for pc, request tracking and FIFO pointers.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (issue_s) begin
                pc_d       = pc_q + ADDR_W'(1);
                req_pc_d   = pc_q;
                inflight_d = 1'b1;
            end else begin
                pc_d       = pc_q;
                inflight_d = 1'b0;
            end
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
        end
    end

    // Fetch datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= {ADDR_W{1'b0}};
            inflight_q <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= {ADDR_W{1'b0}};
                instr_mem_q[i] <= 32'h0000_0000;
            end
        end else if (enq_s) begin
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_instr;
        end
    end

    // Run/halt state machine with registered halted flag; redirect always wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_cap_s) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural synchronous ROM.
module tb_instr_fetch;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr = 32'h0;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [31:0]       out_instr;
    logic              halted;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [31:0] W0 = 32'h00100293;
    localparam logic [31:0] W1 = 32'h00500313;
    localparam logic [31:0] W2 = 32'hFFF00393;

    logic [31:0] rom [16];

    instr_fetch #(
        .ADDR_W(ADDR_W), .RESET_PC(32'h0), .DEPTH(2), .HALT_WORD(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a < 32'd16) return rom[a[3:0]];
        else return 32'h0;
    endfunction

    // Synchronous ROM: word appears the cycle after its address is sampled.
    always @(posedge clk) imem_instr <= rom_word(imem_addr);

    // Hold reset two cycles and release at a falling edge (cycle 0 follows).
    task automatic start_run(input logic rdy);
        rst_n = 1'b0; out_ready = rdy; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want 0", out_pc); end
        tests_run++; if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h want 0", out_instr); end
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted got %b want 0", halted); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [3];
        exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2;
        start_run(1'b1);
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_c1_valid got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            tests_run++; if (out_pc !== 32'(i)) begin tests_failed++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, i); end
            tests_run++; if (out_instr !== exp_w[i]) begin tests_failed++; $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, exp_w[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_tail_valid[%0d] got %b want 0", i, out_valid); end
        end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL stream_halted got %b want 1", halted); end
        tests_run++; if (imem_addr !== 32'h4) begin tests_failed++; $display("FAIL stream_addr got %h want 4", imem_addr); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        start_run(1'b0);
        repeat (5) @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid got %b want 1", out_valid); end
        tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL bp_head got %h want 0", out_pc); end
        tests_run++; if (imem_addr !== 32'h2) begin tests_failed++; $display("FAIL bp_addr got %h want 2", imem_addr); end
        out_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) begin
                tests_run++; if (out_pc !== exp_pc) begin tests_failed++; $display("FAIL bp_order got %h want %h", out_pc, exp_pc); end
                tests_run++; if (out_instr !== rom_word(exp_pc)) begin tests_failed++; $display("FAIL bp_instr got %h want %h", out_instr, rom_word(exp_pc)); end
                exp_pc = exp_pc + 32'd1;
            end
            @(negedge clk);
        end
        tests_run++; if (exp_pc !== 32'd3) begin tests_failed++; $display("FAIL bp_count got %0d want 3", exp_pc); end
    endtask

    task automatic test_redirect();
        start_run(1'b1);
        repeat (3) @(negedge clk);
        tests_run++; if (out_pc !== 32'h1) begin tests_failed++; $display("FAIL redir_pre_pc got %h want 1", out_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h1;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush got %b want 0", out_valid); end
        tests_run++; if (imem_addr !== 32'h1) begin tests_failed++; $display("FAIL redir_addr got %h want 1", imem_addr); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_squash got %b want 0", out_valid); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL redir_valid got %b want 1", out_valid); end
        tests_run++; if (out_pc !== 32'h1) begin tests_failed++; $display("FAIL redir_pc got %h want 1", out_pc); end
        tests_run++; if (out_instr !== W1) begin tests_failed++; $display("FAIL redir_instr got %h want %h", out_instr, W1); end
        @(negedge clk);
        tests_run++; if (out_pc !== 32'h2) begin tests_failed++; $display("FAIL redir_next got %h want 2", out_pc); end
    endtask

    task automatic test_halt_redirect();
        for (int i = 0; i < 20 && halted !== 1'b1; i++) @(negedge clk);
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_reach got %b want 1", halted); end
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL halt_clear got %b want 0", halted); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_empty got %b want 0", out_valid); end
        repeat (2) @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL halt_restart_valid got %b want 1", out_valid); end
        tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL halt_restart_pc got %h want 0", out_pc); end
        tests_run++; if (out_instr !== W0) begin tests_failed++; $display("FAIL halt_restart_instr got %h want %h", out_instr, W0); end
    endtask

    task automatic test_reset_midstream();
        start_run(1'b0);
        repeat (4) @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mrst_full got %b want 1", out_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mrst_valid got %b want 0", out_valid); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL mrst_addr got %h want 0", imem_addr); end
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mrst_restart_valid got %b want 1", out_valid); end
        tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL mrst_restart_pc got %h want 0", out_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        int          xfers;
        logic        do_redir;
        exp_pc = 32'h0; xfers = 0;
        start_run(1'b1);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
            do_redir  = (halted === 1'b1) || ($urandom_range(0, 39) == 0);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests_run++; if (out_pc !== exp_pc) begin tests_failed++; $display("FAIL rnd_pc cycle %0d got %h want %h", c, out_pc, exp_pc); end
                tests_run++; if (out_instr !== rom_word(exp_pc)) begin tests_failed++; $display("FAIL rnd_instr cycle %0d got %h want %h", c, out_instr, rom_word(exp_pc)); end
                exp_pc = exp_pc + 32'd1;
                xfers++;
            end
            if (do_redir) begin
                tgt = 32'($urandom_range(0, 9));
                redirect_valid = 1'b1; redirect_pc = tgt; exp_pc = tgt;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++; if (xfers <= 100) begin tests_failed++; $display("FAIL rnd_xfers got %0d want >100", xfers); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = 32'h0;
        for (int i = 4; i < 10; i++) rom[i] = 32'h1000_0000 | 32'(i);
        rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt_redirect();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
